led_line_reader: RTL and testbench

- Read-back master on the LED panel control bus (ctrl_rd / ctrl_addr / ctrl_rdat / ctrl_done).
- Performs 32 single-pixel reads down one display line, using the same line/column-to-address mapping as the line writer.
- Reassembles the pixels into a 32-bit word: bit c is set when column c is lit.
- Sits beside the line writer in the top level, so the Baby core or a debug path can recover a store line from the framebuffer.

---
 rtl/led_bus_pkg.sv | 27 ++
 rtl/led_line_reader_if.sv | 25 ++
 rtl/led_line_reader.sv | 138 +++++++++++++
 tb/tb_led_line_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bus_pkg.sv
// Shared LED panel bus definitions: FSM encoding, field widths
// and the line/column to byte-address mapping used by reader and writer.
package led_bus_pkg;

    localparam int LINE_W  = 5;
    localparam int COL_W   = 5;
    localparam int ADDR_W  = 16;
    localparam int COLOR_W = 24;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Lines are stored bottom-up: line 0 sits at word 31 of each column.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [LINE_W-1:0] line,
        input logic [COL_W-1:0]  col
    );
        logic [ADDR_W-1:0] word;
        word = (ADDR_W'(col) << 5) + ADDR_W'(5'd31 - line);
        return word << 2;
    endfunction

endpackage

// File: rtl/led_line_reader_if.sv
// LED panel control bus, read side: request/address out,
// colour data and completion pulse back.
interface led_line_reader_if;
    import led_bus_pkg::*;

    logic              ctrl_rd;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [31:0]       ctrl_rdat;
    logic              ctrl_done;

    modport master (
        output ctrl_rd,
        output ctrl_addr,
        input  ctrl_rdat,
        input  ctrl_done
    );

    modport slave (
        input  ctrl_rd,
        input  ctrl_addr,
        output ctrl_rdat,
        output ctrl_done
    );

endinterface

// File: rtl/led_line_reader.sv
// Reads the 32 pixels of one display line back from the panel
// and packs them into a word, bit c set when column c is lit.
module led_line_reader
    import led_bus_pkg::*;
#(
    parameter logic [COLOR_W-1:0] MATCH_MASK = 24'hFFFFFF,
    parameter int unsigned        TIMEOUT    = 1023
) (
    input  logic              clk100,
    input  logic              resetn,
    input  logic              start,
    input  logic [LINE_W-1:0] line,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       value,
    led_line_reader_if.master ctrl
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [31:0]       shift_q, shift_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       value_q, value_d;

    logic hit;
    logic tmo_hit;
    logic unused_rdat_hi;

    assign hit = |(ctrl.ctrl_rdat[COLOR_W-1:0] & MATCH_MASK);
    assign unused_rdat_hi = ^ctrl.ctrl_rdat[31:COLOR_W];

    // Abort fires on the TIMEOUT-th waiting cycle; 0 disables it.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        shift_d = shift_q;
        tmo_d   = tmo_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        value_d = value_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    line_d  = line;
                    col_d   = '0;
                    shift_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                addr_d  = pixel_addr(line_q, col_q);
                rd_d    = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl.ctrl_done) begin
                    rd_d           = 1'b0;
                    shift_d[col_q] = hit;
                    if (col_q == COL_W'(31)) begin
                        state_d = ST_FINISH;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (tmo_hit) begin
                    rd_d    = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FINISH: begin
                value_d = shift_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            col_q   <= '0;
            shift_q <= '0;
            tmo_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            shift_q <= shift_d;
            tmo_q   <= tmo_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            value_q <= value_d;
        end
    end

    assign ctrl.ctrl_rd   = rd_q;
    assign ctrl.ctrl_addr = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign value          = value_q;

endmodule

// File: tb/tb_led_line_reader.sv
// Bench for led_line_reader: panel responder model, address/value
// scoreboard, vector table plus timeout, double-start and reset sequences.
module tb_led_line_reader;

    logic        clk100 = 1'b0;
    logic        resetn = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [4:0]  line_in = '0;
    logic        busy_a, done_a, error_a;
    logic        busy_b, done_b, error_b;
    logic [31:0] value_a, value_b;

    led_line_reader_if bus_a ();
    led_line_reader_if bus_b ();

    led_line_reader u_a (
        .clk100 (clk100),
        .resetn (resetn),
        .start  (start_a),
        .line   (line_in),
        .busy   (busy_a),
        .done   (done_a),
        .error  (error_a),
        .value  (value_a),
        .ctrl   (bus_a)
    );

    led_line_reader #(
        .MATCH_MASK (24'hFF0000),
        .TIMEOUT    (16)
    ) u_b (
        .clk100 (clk100),
        .resetn (resetn),
        .start  (start_b),
        .line   (line_in),
        .busy   (busy_b),
        .done   (done_b),
        .error  (error_b),
        .value  (value_b),
        .ctrl   (bus_b)
    );

    always #5 clk100 = ~clk100;

    int          sel = 0;
    logic        r_done = 1'b0;
    logic [31:0] r_rdat = '0;

    assign bus_a.ctrl_done = (sel == 0) && r_done;
    assign bus_b.ctrl_done = (sel == 1) && r_done;
    assign bus_a.ctrl_rdat = r_rdat;
    assign bus_b.ctrl_rdat = r_rdat;

    wire        m_rd   = (sel == 1) ? bus_b.ctrl_rd   : bus_a.ctrl_rd;
    wire [15:0] m_addr = (sel == 1) ? bus_b.ctrl_addr : bus_a.ctrl_addr;
    wire        m_busy = (sel == 1) ? busy_b  : busy_a;
    wire        m_done = (sel == 1) ? done_b  : done_a;
    wire        m_err  = (sel == 1) ? error_b : error_a;
    wire [31:0] m_val  = (sel == 1) ? value_b : value_a;

    logic [31:0] pix [32][32];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Panel model: answers k cycles after ctrl_rd rises, never for skip_addr.
    int          resp_k = 1;
    bit          resp_rnd = 1'b0;
    logic [15:0] skip_addr = 16'hFFFF;
    int          rcnt = 0;
    int          cur_k = 1;

    always @(posedge clk100) begin
        #1;
        if (r_done) begin
            r_done = 1'b0;
            rcnt = 0;
        end else if (m_rd && m_addr != skip_addr) begin
            if (rcnt == 0)
                cur_k = resp_rnd ? int'($urandom_range(1, 8)) : resp_k;
            rcnt++;
            if (rcnt >= cur_k) begin
                r_rdat = pix[5'd31 - m_addr[6:2]][m_addr[11:7]];
                r_done = 1'b1;
            end
        end else begin
            rcnt = 0;
        end
    end

    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_val_q [$];
    logic        prev_rd = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] held_addr = '0;
    int          n_reads = 0;
    int          n_done = 0;
    int          n_err = 0;

    always @(negedge clk100) begin
        if (resetn) begin
            if (m_rd && !prev_rd) begin
                n_reads++;
                held_addr = m_addr;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got addr %h, want no read", m_addr);
                end else begin
                    chk("addr", 32'(m_addr), 32'(exp_addr_q.pop_front()));
                end
            end else if (m_rd && prev_rd) begin
                chk("addr_hold", 32'(m_addr), 32'(held_addr));
            end
            if (m_done) begin
                n_done++;
                chk("done_width", 32'(prev_done), 32'd0);
                if (exp_val_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got value %h, want no done", m_val);
                end else begin
                    chk("value", m_val, exp_val_q.pop_front());
                end
            end
            if (m_err)
                n_err++;
        end
        prev_rd = m_rd;
        prev_done = m_done;
    end

    typedef struct {
        int          sel;
        logic [4:0]  ln;
        logic [31:0] pat;
        logic [31:0] on;
        logic [31:0] off;
        int          k;
        bit          rnd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [15:0] ref_addr(input int ln, input int col);
        return 16'(((col * 32) + 31 - ln) * 4);
    endfunction

    task automatic fill(input logic [4:0] ln, input logic [31:0] pat,
                        input logic [31:0] on, input logic [31:0] off);
        for (int c = 0; c < 32; c++)
            pix[ln][c] = pat[c] ? on : off;
    endtask

    task automatic prime(input vec_t v, input int ncols, input bit want_val);
        sel = v.sel;
        resp_k = v.k;
        resp_rnd = v.rnd;
        fill(v.ln, v.pat, v.on, v.off);
        exp_addr_q.delete();
        exp_val_q.delete();
        for (int c = 0; c < ncols; c++)
            exp_addr_q.push_back(ref_addr(int'(v.ln), c));
        if (want_val)
            exp_val_q.push_back(v.exp);
        n_reads = 0;
        n_done = 0;
        n_err = 0;
    endtask

    task automatic pulse_start(input logic [4:0] ln);
        @(posedge clk100);
        #1;
        line_in = ln;
        if (sel == 1) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk100);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int lat_exp);
        int lat;
        lat = 0;
        while (!m_done && lat < 3000) begin
            @(negedge clk100);
            lat++;
            if (lat == 1)
                chk("busy_rise", 32'(m_busy), 32'd1);
        end
        if (!m_done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles, want done", lat);
        end else if (lat_exp >= 0) begin
            chk("latency", 32'(lat - 1), 32'(lat_exp));
        end
    endtask

    task automatic read_line(input vec_t v);
        prime(v, 32, 1'b1);
        pulse_start(v.ln);
        wait_done(v.lat);
        repeat (3) @(negedge clk100);
        chk("reads", 32'(n_reads), 32'd32);
        chk("dones", 32'(n_done), 32'd1);
        chk("errors", 32'(n_err), 32'd0);
        chk("busy_fall", 32'(m_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        vecs[0] = '{0, 5'd5,  32'hA5A5_0F0F, 32'h0000FF00, 32'hAB000000, 1, 1'b0, 32'hA5A5_0F0F, 65};
        vecs[1] = '{0, 5'd5,  32'hA5A5_0F0F, 32'h0000FF00, 32'hAB000000, 3, 1'b0, 32'hA5A5_0F0F, 129};
        vecs[2] = '{0, 5'd5,  32'hA5A5_0F0F, 32'h0000FF00, 32'hAB000000, 1, 1'b1, 32'hA5A5_0F0F, -1};
        vecs[3] = '{0, 5'd31, 32'h8000_0001, 32'h00000001, 32'hFF000000, 2, 1'b0, 32'h8000_0001, 97};
        vecs[4] = '{1, 5'd9,  32'h5555_5555, 32'h00FF0000, 32'h0000FF00, 1, 1'b0, 32'h5555_5555, 65};
        vecs[5] = '{1, 5'd3,  32'hFFFF_FFFF, 32'h0000FF00, 32'h00000000, 1, 1'b0, 32'h0000_0000, 65};
        vecs[6] = '{1, 5'd5,  32'hA5A5_0F0F, 32'h00800000, 32'hFF00FFFF, 2, 1'b0, 32'hA5A5_0F0F, 97};

        repeat (3) @(negedge clk100);
        chk("rst_rd_a",   32'(bus_a.ctrl_rd),   32'd0);
        chk("rst_addr_a", 32'(bus_a.ctrl_addr), 32'd0);
        chk("rst_busy_a", 32'(busy_a),          32'd0);
        chk("rst_done_a", 32'(done_a),          32'd0);
        chk("rst_err_a",  32'(error_a),         32'd0);
        chk("rst_val_a",  value_a,              32'd0);
        chk("rst_rd_b",   32'(bus_b.ctrl_rd),   32'd0);
        chk("rst_busy_b", 32'(busy_b),          32'd0);
        chk("rst_val_b",  value_b,              32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk100);

        for (int i = 0; i < 7; i++)
            read_line(vecs[i]);

        // Timeout: column 7 of line 5 on the TIMEOUT=16 instance never answers.
        v = vecs[6];
        skip_addr = ref_addr(5, 7);
        prime(v, 8, 1'b0);
        pulse_start(v.ln);
        n = 0;
        while (!(m_rd && m_addr == skip_addr) && n < 500) begin
            @(negedge clk100);
            n++;
        end
        chk("tmo_reached_col7", 32'(m_addr), 32'(skip_addr));
        n = 0;
        while (!m_err && n < 100) begin
            @(negedge clk100);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk("tmo_rd", 32'(m_rd), 32'd0);
        chk("tmo_busy", 32'(m_busy), 32'd0);
        chk("tmo_value", m_val, 32'hA5A5_0F0F);
        @(negedge clk100);
        chk("tmo_err_width", 32'(m_err), 32'd0);
        repeat (5) @(negedge clk100);
        chk("tmo_no_done", 32'(n_done), 32'd0);
        chk("tmo_reads", 32'(n_reads), 32'd8);
        skip_addr = 16'hFFFF;

        // Second start while busy must be dropped.
        v = '{0, 5'd7, 32'h0F0F_00FF, 32'h00FFFFFF, 32'h00000000, 1, 1'b0, 32'h0F0F_00FF, -1};
        prime(v, 32, 1'b1);
        pulse_start(v.ln);
        repeat (10) @(negedge clk100);
        pulse_start(5'd2);
        wait_done(-1);
        repeat (80) @(negedge clk100);
        chk("dbl_reads", 32'(n_reads), 32'd32);
        chk("dbl_dones", 32'(n_done), 32'd1);
        chk("dbl_busy", 32'(m_busy), 32'd0);

        // Asynchronous reset in the middle of column 12.
        v = vecs[0];
        prime(v, 32, 1'b1);
        pulse_start(v.ln);
        n = 0;
        while (!(m_rd && m_addr == ref_addr(5, 12)) && n < 500) begin
            @(negedge clk100);
            n++;
        end
        chk("rst_reached_col12", 32'(m_addr), 32'(ref_addr(5, 12)));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_rd",   32'(bus_a.ctrl_rd),   32'd0);
        chk("arst_addr", 32'(bus_a.ctrl_addr), 32'd0);
        chk("arst_busy", 32'(busy_a),          32'd0);
        chk("arst_done", 32'(done_a),          32'd0);
        chk("arst_err",  32'(error_a),         32'd0);
        chk("arst_val",  value_a,              32'd0);
        exp_addr_q.delete();
        exp_val_q.delete();
        repeat (2) @(negedge clk100);
        resetn = 1'b1;
        repeat (2) @(negedge clk100);
        v = '{0, 5'd0, 32'h3C5A_A5C3, 32'h000000FF, 32'hEE000000, 1, 1'b0, 32'h3C5A_A5C3, 65};
        read_line(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
